// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU encodings: MULTU FSM states and HI/LO read-mux selects.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        MULTU_IDLE = 2'd0,
        MULTU_RUN  = 2'd1,
        MULTU_DONE = 2'd2
    } multu_state_e;

    localparam logic [1:0] HILO_SEL_ALU = 2'b00;
    localparam logic [1:0] HILO_SEL_HI  = 2'b01;
    localparam logic [1:0] HILO_SEL_LO  = 2'b10;
    localparam logic [1:0] HILO_SEL_SHT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : multu_datapath
// Purpose  : Shift-add unsigned multiplier datapath (one partial product/step).
//            Option MULTU_EARLY_EXIT_EN exposes a remaining-multiplier-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module multu_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
`ifdef MULTU_EARLY_EXIT_EN
    output logic               mplier_rest_zero,
`endif
    output logic [2*WIDTH-1:0] prod_next
);

    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;

    // Product after the step performed in the current cycle
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULTU_EARLY_EXIT_EN
    assign mplier_rest_zero = (mplier_q[WIDTH-1:1] == '0);
`endif

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            prod_d   = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = prod_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit
// Purpose  : Multi-cycle MULTU with HI/LO registers, read mux and hazard stall.
//            Option MULTU_EARLY_EXIT_EN ends RUN once remaining multiplier is 0.
// Revision : 1.0 - initial release
// ============================================================================
module multu_hilo_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hilo_data,
    output logic             busy,
    output logic             done,
    output logic             hilo_stall
);

    multu_state_e       state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               load;
    logic               step;
    logic               last_step;
    logic [2*WIDTH-1:0] prod_next;

`ifdef MULTU_EARLY_EXIT_EN
    logic mplier_rest_zero;
    assign last_step = mplier_rest_zero;
`else
    localparam int CNT_W = $clog2(WIDTH);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    multu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (load),
        .step             (step),
        .op_a             (op_a),
        .op_b             (op_b),
`ifdef MULTU_EARLY_EXIT_EN
        .mplier_rest_zero (mplier_rest_zero),
`endif
        .prod_next        (prod_next)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
`ifndef MULTU_EARLY_EXIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            MULTU_RUN: begin
                // Flush abandons the multiply; HI/LO keep the previous result
                if (flush) begin
                    state_d = MULTU_IDLE;
                end else begin
                    step = 1'b1;
`ifndef MULTU_EARLY_EXIT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                    if (last_step) begin
                        hi_d    = prod_next[2*WIDTH-1:WIDTH];
                        lo_d    = prod_next[WIDTH-1:0];
                        state_d = MULTU_DONE;
                    end
                end
            end
            default: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_d = MULTU_RUN;
`ifndef MULTU_EARLY_EXIT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = MULTU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MULTU_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
`ifndef MULTU_EARLY_EXIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifndef MULTU_EARLY_EXIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy       = (state_q == MULTU_RUN);
    assign done       = (state_q == MULTU_DONE);
    assign hilo_stall = busy && ((hilo_sel == HILO_SEL_HI) || (hilo_sel == HILO_SEL_LO));

    always_comb begin
        case (hilo_sel)
            HILO_SEL_HI: hilo_data = hi_q;
            HILO_SEL_LO: hilo_data = lo_q;
            default:     hilo_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multu_hilo_unit
// Purpose  : Directed self-checking bench for multu_hilo_unit with a result
//            scoreboard. Honours MULTU_EARLY_EXIT_EN for RUN-length checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multu_hilo_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           flush = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic [1:0]     hilo_sel = 2'b00;
    logic [W-1:0]   hilo_data;
    logic           busy;
    logic           done;
    logic           hilo_stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [2*W-1:0] exp_q[$];

    multu_hilo_unit #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .hilo_sel   (hilo_sel),
        .hilo_data  (hilo_data),
        .busy       (busy),
        .done       (done),
        .hilo_stall (hilo_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int exp_cycles(input logic [W-1:0] b);
        int n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`ifdef MULTU_EARLY_EXIT_EN
        return n;
`else
        return (n > 0) ? W : W;
`endif
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(p);
        t0 = cyc;
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [1:0] s;
        s = hilo_sel;
        hilo_sel = 2'b01;
        #1 hi = hilo_data;
        hilo_sel = 2'b10;
        #1 lo = hilo_data;
        hilo_sel = s;
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int n;
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_len"}, 64'(cyc - t0), 64'(exp_len));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        read_hilo(hi, lo);
        chk({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hi, lo, ra, rb;
        int seen;

        repeat (3) tick();
        hilo_sel = 2'b01;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(hilo_stall), 64'd0);
        read_hilo(hi, lo);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        hilo_sel = 2'b00;
        rst_n = 1'b1;
        tick();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max", exp_cycles(32'hFFFF_FFFF));
        read_hilo(hi, lo);
        chk("max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        chk("max_lo_const", 64'(lo), 64'h0000_0001);
        tick();
        chk("max_done_1cyc", 64'(done), 64'd0);
        chk("max_idle", 64'(busy), 64'd0);

        issue(32'd7, 32'd6);
        hilo_sel = 2'b10;
        #1;
        chk("rd_run_stall", 64'(hilo_stall), 64'd1);
        chk("rd_run_oldlo", 64'(hilo_data), 64'h1);
        wait_done("rd", exp_cycles(32'd6));
        chk("rd_done_lo", 64'(hilo_data), 64'd42);
        chk("rd_done_stall", 64'(hilo_stall), 64'd0);
        hilo_sel = 2'b00;
        tick();

        issue(32'h1234_5678, 32'h8000_0011);
        repeat (3) tick();
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op_a = 32'h0BAD_F00D; op_b = 32'hFFFF_0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        wait_done("ign", exp_cycles(32'h8000_0011));
        issue(32'h0001_0000, 32'h0000_FFFF);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_done", 64'(done), 64'd0);
        wait_done("restart", exp_cycles(32'h0000_FFFF));
        tick();

        issue(32'd5, 32'hF000_0000);
        void'(exp_q.pop_back());
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        read_hilo(hi, lo);
        chk("flush_hi", 64'(hi), 64'h0000_0000);
        chk("flush_lo", 64'(lo), 64'hFFFF_0000);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("sf_idle", 64'(busy), 64'd0);
        tick();
        chk("sf_nodone", 64'(done), 64'd0);

        issue(32'd3, 32'hFFFF_FFFF);
        void'(exp_q.pop_back());
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        read_hilo(hi, lo);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        tick();
        chk("arst_nodone", 64'(done), 64'd0);
        rst_n = 1'b1;
        issue(32'd9, 32'd11);
        chk("post_rst_busy", 64'(busy), 64'd1);
        wait_done("post_rst", exp_cycles(32'd11));
        tick();

        issue(32'h0000_ABCD, 32'h0000_0000);
        wait_done("b0", exp_cycles(32'h0));
        tick();
        issue(32'h1357_9BDF, 32'h0000_0100);
        wait_done("b100", exp_cycles(32'h100));
        tick();

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue(ra, rb);
            wait_done("rand", exp_cycles(rb));
            tick();
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
